// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA stream layout, screen geometry, glyph and ASCII constants
package vga_pkg;
  localparam int ACTIVE = 0;
  localparam int VS = 1;
  localparam int HS = 2;
  localparam int YC_LSB = 3;
  localparam int YC_MSB = 12;
  localparam int XC_LSB = 13;
  localparam int XC_MSB = 22;
  localparam int SCR_W = 800;
  localparam int SCR_H = 600;
  localparam int GLYPH_PX = 8;
  localparam int GLYPH_SEP = 2;
  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam logic [7:0] ASCII_A = 8'h41;
endpackage

// File: rtl/nib2ascii.sv
// nib2ascii: 4-bit nibble to upper-case hex ASCII digit
module nib2ascii
  import vga_pkg::*;
(
  input  logic [3:0] nib,
  output logic [7:0] ascii
);
  always_comb ascii = nib < 4'd10 ? ASCII_0 + {4'd0, nib} : ASCII_A + {4'd0, nib} - 8'd10;
endmodule

// File: rtl/vga_reg_sched.sv
// vga_reg_sched: frame-synchronous shadowing of byte registers and per-pixel
// hex-glyph scheduling onto a single shared renderer.
module vga_reg_sched
  import vga_pkg::*;
#(
  parameter int N_SLOTS = 4,
  parameter int X0 = 100,
  parameter int Y0 = 100,
  parameter int PITCH_Y = 12,
  parameter int GLYPH = GLYPH_PX,
  parameter int SEP = GLYPH_SEP
) (
  input  logic                 px_clk,
  input  logic                 reset,
  input  logic [22:0]          strVGA,
  input  logic [8*N_SLOTS-1:0] reg_data,
  input  logic [N_SLOTS-1:0]   upd_req,
  output logic [N_SLOTS-1:0]   upd_ack,
  output logic [22:0]          strVGA_o,
  output logic [9:0]           x_pos,
  output logic [9:0]           y_pos,
  output logic [7:0]           character,
  output logic                 in_zone
);
  localparam logic [10:0] HI_L = 11'(X0);
  localparam logic [10:0] HI_R = 11'(X0 + GLYPH);
  localparam logic [10:0] LO_L = 11'(X0 + GLYPH + SEP);
  localparam logic [10:0] LO_R = 11'(X0 + 2 * GLYPH + SEP);
  logic [8*N_SLOTS-1:0] shadow;
  logic [N_SLOTS-1:0] pending, commit;
  logic [10:0] xc, yc;
  logic frame_end, hi, lo, hit, zone;
  logic [9:0] row_top;
  logic [7:0] row_byte, ascii;
  logic [3:0] nib;
  // 11-bit coordinates keep box limits near 1023 from wrapping
  assign xc = {1'b0, strVGA[XC_MSB:XC_LSB]};
  assign yc = {1'b0, strVGA[YC_MSB:YC_LSB]};
  assign frame_end = xc == 11'(SCR_W - 1) && yc == 11'(SCR_H - 1);
  assign commit = frame_end ? pending | upd_req : '0;
  assign hi = xc >= HI_L && xc < HI_R;
  assign lo = xc >= LO_L && xc < LO_R;
  // Descending scan so the lowest slot index wins any overlap
  always_comb begin
    hit = 1'b0;
    row_top = '0;
    row_byte = '0;
    for (int k = N_SLOTS - 1; k >= 0; k--)
      if (yc >= 11'(Y0 + k * PITCH_Y) && yc < 11'(Y0 + k * PITCH_Y + GLYPH)) begin
        hit = 1'b1;
        row_top = 10'(Y0 + k * PITCH_Y);
        row_byte = shadow[8*k+:8];
      end
  end
  assign zone = strVGA[ACTIVE] && hit && (hi || lo);
  assign nib = hi ? row_byte[7:4] : row_byte[3:0];
  nib2ascii u_nib2ascii (.nib(nib), .ascii(ascii));
  always_ff @(posedge px_clk or posedge reset)
    if (reset) begin
      shadow <= '0;
      pending <= '0;
      upd_ack <= '0;
      strVGA_o <= '0;
      x_pos <= '0;
      y_pos <= '0;
      character <= ASCII_0;
      in_zone <= 1'b0;
    end else begin
      strVGA_o <= strVGA;
      pending <= frame_end ? '0 : pending | upd_req;
      upd_ack <= commit;
      for (int k = 0; k < N_SLOTS; k++)
        if (commit[k]) shadow[8*k+:8] <= reg_data[8*k+:8];
      in_zone <= zone;
      if (zone) begin
        x_pos <= hi ? 10'(X0) : 10'(X0 + GLYPH + SEP);
        y_pos <= row_top;
        character <= ascii;
      end
    end
endmodule
